// File: rtl/uart_fifo_pkg.sv
// Shared types and width helpers for the UART transmit FIFO.
package uart_fifo_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int PTR_W     = $clog2(DEPTH_DEF) + 1;

    typedef logic [15:0] stat_cnt_t;

    typedef struct packed {
        logic             full;
        logic             almost_full;
        logic             overflow;
        logic [PTR_W-1:0] count;
    } fifo_status_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular word store: one synchronous write port, one async read port.
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter handshake.
// Optional pop counter output tx_word_cnt under UART_TX_FIFO_STATS_EN.
module uart_tx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_valid,
`ifdef UART_TX_FIFO_STATS_EN
    output logic [15:0]              tx_word_cnt,
`endif
    input  logic                     tx_ready
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("uart_tx_fifo: AF_LEVEL must be in 1..DEPTH");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] count_nxt;
    logic          wr_acc;
    logic          pop;

    // Registered full gates the write; a pop in the same cycle does not help.
    assign wr_acc   = wr_en && !full;
    assign tx_valid = (count != '0);
    assign pop      = tx_valid && tx_ready;

    always_comb begin
        wr_ptr_nxt = wr_ptr + {{(PW-1){1'b0}}, wr_acc};
        rd_ptr_nxt = rd_ptr + {{(PW-1){1'b0}}, pop};
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            full        <= (count_nxt == PW'(DEPTH));
            almost_full <= (count_nxt >= PW'(AF_LEVEL));
            overflow    <= overflow | (wr_en & full);
        end
    end

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !flush),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (tx_data)
    );

`ifdef UART_TX_FIFO_STATS_EN
    stat_cnt_t word_cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            word_cnt <= '0;
        end else if (flush) begin
            word_cnt <= '0;
        end else if (pop && word_cnt != '1) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

    assign tx_word_cnt = word_cnt;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table plus multi-cycle sequences.
module tb_uart_tx_fifo;
    import uart_fifo_pkg::*;

    logic       clk;
    logic       rst_l;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] tx_word_cnt;
`endif

    int total = 0;
    int bad   = 0;

    uart_tx_fifo dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .count       (count),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
`ifdef UART_TX_FIFO_STATS_EN
        .tx_word_cnt (tx_word_cnt),
`endif
        .tx_ready    (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         fl;
        logic         we;
        logic [7:0]   wd;
        logic         rdy;
        fifo_status_t st;
        logic         v;
        logic         dchk;
        logic [7:0]   d;
    } vec_t;

    function automatic fifo_status_t mk(
        input logic f, input logic af,
        input logic ov, input int c);
        fifo_status_t s;
        s.full        = f;
        s.almost_full = af;
        s.overflow    = ov;
        s.count       = c[4:0];
        return s;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_st(input string name, input fifo_status_t exp);
        fifo_status_t s;
        s = {full, almost_full, overflow, count};
        chk(name, 32'(s), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        flush    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t     vt [9];
        logic [7:0] q [$];
        int       pops;
        int       guard;

        rst_l = 1'b0;
        idle_in();
        #3;
        chk_st("reset_status", mk(0, 0, 0, 0));
        chk("reset_valid", 32'(tx_valid), 0);
`ifdef UART_TX_FIFO_STATS_EN
        chk("reset_stats", 32'(tx_word_cnt), 0);
`endif
        @(posedge clk);
        #1;
        rst_l = 1'b1;

        vt[0] = '{1'b0, 1'b0, 8'h00, 1'b0, mk(0,0,0,0), 1'b0, 1'b0, 8'h00};
        vt[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, mk(0,0,0,1), 1'b1, 1'b1, 8'hA5};
        vt[2] = '{1'b0, 1'b0, 8'h00, 1'b1, mk(0,0,0,0), 1'b0, 1'b0, 8'h00};
        vt[3] = '{1'b0, 1'b1, 8'h11, 1'b1, mk(0,0,0,1), 1'b1, 1'b1, 8'h11};
        vt[4] = '{1'b0, 1'b1, 8'h22, 1'b1, mk(0,0,0,1), 1'b1, 1'b1, 8'h22};
        vt[5] = '{1'b0, 1'b1, 8'h33, 1'b0, mk(0,0,0,2), 1'b1, 1'b1, 8'h22};
        vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, mk(0,0,0,1), 1'b1, 1'b1, 8'h33};
        vt[7] = '{1'b1, 1'b1, 8'h44, 1'b1, mk(0,0,0,0), 1'b0, 1'b0, 8'h00};
        vt[8] = '{1'b0, 1'b0, 8'h00, 1'b0, mk(0,0,0,0), 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 9; i++) begin
            flush    = vt[i].fl;
            wr_en    = vt[i].we;
            wr_data  = vt[i].wd;
            tx_ready = vt[i].rdy;
            step();
            chk_st($sformatf("vec%0d_status", i), vt[i].st);
            chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vt[i].v));
            if (vt[i].dchk) begin
                chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vt[i].d));
            end
        end
        idle_in();

        // Fill with ready low, then one write too many.
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
            chk_st($sformatf("fill%0d", i), mk(i == 15, i >= 11, 0, i + 1));
            chk("fill_head", 32'(tx_data), 0);
        end
        wr_data = 8'hEE;
        step();
        chk_st("overflow_set", mk(1, 1, 1, 16));
        chk("overflow_head", 32'(tx_data), 0);
        idle_in();

        // Drain with frame-time gaps between ready pulses.
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain%0d_valid", j), 32'(tx_valid), 1);
            chk($sformatf("drain%0d_data", j), 32'(tx_data), 32'(j));
            tx_ready = 1'b1;
            step();
            tx_ready = 1'b0;
            chk_st($sformatf("drain%0d_st", j),
                   mk(0, (15 - j) >= 12, 1, 15 - j));
            for (int k = 0; k < 6; k++) step();
            if (j < 15) begin
                chk($sformatf("hold%0d_data", j), 32'(tx_data), 32'(j + 1));
            end
        end
        chk("drained_valid", 32'(tx_valid), 0);

        // Refill, overflow again, drain to 5, then flush with a write.
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h50 + i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tx_ready = 1'b1;
            step();
        end
        tx_ready = 1'b0;
        chk_st("pre_flush", mk(0, 0, 1, 5));
        chk("pre_flush_data", 32'(tx_data), 32'h5B);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        step();
        idle_in();
        chk_st("flush_status", mk(0, 0, 0, 0));
        chk("flush_valid", 32'(tx_valid), 0);
`ifdef UART_TX_FIFO_STATS_EN
        chk("flush_stats", 32'(tx_word_cnt), 0);
`endif
        step();
        chk_st("flush_discard", mk(0, 0, 0, 0));

        // Steady stream: 3 preloaded, 40 write+pop cycles, then drain.
        pops = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h70 + i);
            q.push_back(wr_data);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("stream%0d_data", i), 32'(tx_data), 32'(q[0]));
            wr_en    = 1'b1;
            wr_data  = 8'(8'h80 + i);
            tx_ready = 1'b1;
            void'(q.pop_front());
            q.push_back(wr_data);
            pops++;
            step();
            chk($sformatf("stream%0d_cnt", i), 32'(count), 3);
        end
        wr_en = 1'b0;
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            chk("tail_data", 32'(tx_data), 32'(q[0]));
            tx_ready = 1'b1;
            void'(q.pop_front());
            pops++;
            step();
            guard++;
        end
        tx_ready = 1'b0;
        chk("tail_empty", 32'(tx_valid), 0);
`ifdef UART_TX_FIFO_STATS_EN
        chk("stats_pops", 32'(tx_word_cnt), 32'(pops));
`endif

        // Asynchronous reset with data pending.
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        step();
        step();
        wr_en = 1'b0;
        chk("pre_rst_valid", 32'(tx_valid), 1);
        #1;
        rst_l = 1'b0;
        #1;
        chk("async_rst_valid", 32'(tx_valid), 0);
        chk_st("async_rst_st", mk(0, 0, 0, 0));
`ifdef UART_TX_FIFO_STATS_EN
        chk("async_rst_stats", 32'(tx_word_cnt), 0);
`endif
        #1;
        rst_l = 1'b1;
        step();
        chk_st("post_rst_st", mk(0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
